// File: rtl/led_fade_driver.sv
// PWM LED driver: each channel's brightness ramps toward its PIO on/off target
// once per PWM period, giving smooth fade-in and fade-out on the board LEDs.
module led_fade_driver #(
  parameter int N_LEDS    = 14,
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 195,
  parameter int FADE_STEP = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_LEDS-1:0] led_target,
  input  logic              enable,
  output logic [N_LEDS-1:0] led_out,
  output logic              busy
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int LW   = PWM_BITS + 1;

  localparam logic [PWM_BITS-1:0] MAX     = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);
  localparam logic [PS_W-1:0]     PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [PS_W-1:0]     PS_ONE  = PS_W'(1);
  localparam logic [LW-1:0]       STEP    = LW'(FADE_STEP);
  localparam logic [LW-1:0]       MAX_EXT = {1'b0, MAX};

  logic [PS_W-1:0]                    presc_q, presc_d;
  logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
  logic [N_LEDS-1:0]                  target_q, target_d;
  logic [N_LEDS-1:0][PWM_BITS-1:0]    level_q, level_d;
  logic [N_LEDS-1:0]                  led_out_q, led_out_d;
  logic                               busy_q, busy_d;

  logic                               tick_s;
  logic                               period_end_s;
  logic [LW-1:0]                      up_s;
  logic [LW-1:0]                      dn_s;
  logic [N_LEDS-1:0]                  chan_busy_s;

  always_comb begin
    target_d     = led_target;
    tick_s       = (presc_q == PS_LAST);
    period_end_s = 1'b0;
    if (tick_s) begin
      presc_d   = {PS_W{1'b0}};
      pwm_cnt_d = pwm_cnt_q + PWM_ONE;
    end else begin
      presc_d   = presc_q + PS_ONE;
      pwm_cnt_d = pwm_cnt_q;
    end
    if (tick_s && (pwm_cnt_q == MAX)) begin
      period_end_s = 1'b1;
    end else begin
      period_end_s = 1'b0;
    end
  end

  // Ramp arithmetic is one bit wider than a level so the clamp sees overflow/borrow.
  always_comb begin
    level_d     = level_q;
    led_out_d   = {N_LEDS{1'b0}};
    chan_busy_s = {N_LEDS{1'b0}};
    up_s        = {LW{1'b0}};
    dn_s        = {LW{1'b0}};
    busy_d      = 1'b0;
    for (int i = 0; i < N_LEDS; i++) begin
      up_s = {1'b0, level_q[i]} + STEP;
      dn_s = {1'b0, level_q[i]} - STEP;
      if (!enable) begin
        level_d[i] = {PWM_BITS{1'b0}};
      end else if (period_end_s) begin
        if (target_q[i]) begin
          if (up_s > MAX_EXT) begin
            level_d[i] = MAX;
          end else begin
            level_d[i] = up_s[PWM_BITS-1:0];
          end
        end else begin
          if (dn_s[PWM_BITS]) begin
            level_d[i] = {PWM_BITS{1'b0}};
          end else begin
            level_d[i] = dn_s[PWM_BITS-1:0];
          end
        end
      end else begin
        level_d[i] = level_q[i];
      end

      // Full scale is forced on so the wrap at MAX leaves no dark tick.
      led_out_d[i] = enable && ((level_q[i] == MAX) || (pwm_cnt_q < level_q[i]));

      if (target_q[i]) begin
        chan_busy_s[i] = (level_q[i] != MAX);
      end else begin
        chan_busy_s[i] = (level_q[i] != {PWM_BITS{1'b0}});
      end
    end
    busy_d = enable && (|chan_busy_s);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= {PS_W{1'b0}};
      pwm_cnt_q <= {PWM_BITS{1'b0}};
      target_q  <= {N_LEDS{1'b0}};
      level_q   <= {(N_LEDS*PWM_BITS){1'b0}};
      led_out_q <= {N_LEDS{1'b0}};
      busy_q    <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      target_q  <= target_d;
      level_q   <= level_d;
      led_out_q <= led_out_d;
      busy_q    <= busy_d;
    end
  end

  assign led_out = led_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver with PWM_BITS=4, PRESCALE=1, FADE_STEP=4:
// each PWM period is 16 clocks; expected per-period duty/busy is queued up front.
module tb_led_fade_driver;

  localparam int N = 14;

  logic         clk;
  logic         reset;
  logic [N-1:0] led_target;
  logic         enable;
  logic [N-1:0] led_out;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Clock edges since the last reset release; PWM count equals cyc mod 16.
  int cyc;

  typedef struct {
    int   duty;
    logic busy;
    logic upper;
  } exp_t;

  exp_t         exp_q[$];
  int           chg_cyc = -1;
  logic [N-1:0] chg_val = '0;

  led_fade_driver #(
    .N_LEDS(N),
    .PWM_BITS(4),
    .PRESCALE(1),
    .FADE_STEP(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .led_target(led_target),
    .enable(enable),
    .led_out(led_out),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    if (cyc == chg_cyc) begin
      led_target = chg_val;
      chg_cyc    = -1;
    end
  endtask

  task automatic push_exp(input int d, input logic b, input logic u);
    exp_t e;
    e.duty  = d;
    e.busy  = b;
    e.upper = u;
    exp_q.push_back(e);
  endtask

  // Measure whole PWM periods (samples at cyc 16m+1 .. 16m+16) and score them.
  task automatic measure(input int n);
    for (int w = 0; w < n; w++) begin
      int   guard;
      int   on0;
      logic up;
      exp_t e;
      guard = 0;
      on0   = 0;
      up    = 1'b0;
      while (((cyc % 16) != 0) && (guard < 40)) begin
        step();
        guard++;
      end
      if ((cyc % 16) != 0) begin
        total++;
        bad++;
        $display("FAIL window_align cyc=%0d want multiple of 16", cyc);
      end
      for (int k = 0; k < 16; k++) begin
        step();
        on0 += int'(led_out[0]);
        up  = up | (|led_out[N-1:1]);
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard_empty at cyc=%0d", cyc);
      end else begin
        e = exp_q.pop_front();
        total++;
        if (on0 !== e.duty) begin
          bad++;
          $display("FAIL duty cyc=%0d got=%0d want=%0d", cyc, on0, e.duty);
        end
        total++;
        if (busy !== e.busy) begin
          bad++;
          $display("FAIL busy_end cyc=%0d got=%b want=%b", cyc, busy, e.busy);
        end
        total++;
        if (up !== e.upper) begin
          bad++;
          $display("FAIL upper_leds cyc=%0d got=%b want=%b", cyc, up, e.upper);
        end
      end
    end
  endtask

  task automatic do_reset(input logic [N-1:0] val);
    reset      = 1'b1;
    led_target = val;
    enable     = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_release();
    step();
    total++;
    if ((busy !== 1'b0) || (led_out !== 14'h0000)) begin
      bad++;
      $display("FAIL release_cyc1 got busy=%b led=%h want busy=0 led=0000", busy, led_out);
    end
    step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL release_cyc2_busy got=%b want=1", busy);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    enable     = 1'b1;
    led_target = 14'h3FFF;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if ((led_out !== 14'h0000) || (busy !== 1'b0)) begin
        bad++;
        $display("FAIL in_reset got led=%h busy=%b want led=0000 busy=0", led_out, busy);
      end
    end
    reset = 1'b0;
    check_release();
  endtask

  task automatic test_fade_up();
    do_reset(14'h0001);
    step();
    step();
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL fade_up_busy got=%b want=1", busy);
    end
    push_exp(4, 1'b1, 1'b0);
    push_exp(8, 1'b1, 1'b0);
    push_exp(12, 1'b1, 1'b0);
    push_exp(16, 1'b0, 1'b0);
    push_exp(16, 1'b0, 1'b0);
    measure(5);
  endtask

  task automatic test_fade_down();
    led_target = 14'h0000;
    push_exp(16, 1'b1, 1'b0);
    push_exp(11, 1'b1, 1'b0);
    push_exp(7, 1'b1, 1'b0);
    push_exp(3, 1'b1, 1'b0);
    push_exp(0, 1'b0, 1'b0);
    push_exp(0, 1'b0, 1'b0);
    measure(6);
  endtask

  // Reversal mid-fade, then a target change landing on the period_end edge itself.
  task automatic test_reversal();
    led_target = 14'h0001;
    push_exp(0, 1'b1, 1'b0);
    push_exp(4, 1'b1, 1'b0);
    measure(2);
    led_target = 14'h0000;
    chg_cyc    = 255;
    chg_val    = 14'h0001;
    push_exp(8, 1'b1, 1'b0);
    push_exp(4, 1'b1, 1'b0);
    push_exp(0, 1'b1, 1'b0);
    push_exp(4, 1'b1, 1'b0);
    measure(4);
  endtask

  task automatic test_enable();
    logic any_on;
    push_exp(8, 1'b1, 1'b0);
    measure(1);
    step();
    step();
    total++;
    if ((led_out[0] !== 1'b1) || (busy !== 1'b1)) begin
      bad++;
      $display("FAIL pre_disable got led0=%b busy=%b want led0=1 busy=1", led_out[0], busy);
    end
    enable = 1'b0;
    step();
    total++;
    if ((led_out !== 14'h0000) || (busy !== 1'b0)) begin
      bad++;
      $display("FAIL disable_1clk got led=%h busy=%b want led=0000 busy=0", led_out, busy);
    end
    any_on = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      any_on = any_on | (|led_out) | busy;
    end
    total++;
    if (any_on !== 1'b0) begin
      bad++;
      $display("FAIL disabled_hold got=%b want=0", any_on);
    end
    enable = 1'b1;
    push_exp(4, 1'b1, 1'b0);
    measure(1);
  endtask

  task automatic test_async_reset();
    push_exp(8, 1'b1, 1'b0);
    measure(1);
    for (int k = 0; k < 4; k++) step();
    total++;
    if (led_out[0] !== 1'b1) begin
      bad++;
      $display("FAIL pre_async_led got=%b want=1", led_out[0]);
    end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ((led_out !== 14'h0000) || (busy !== 1'b0)) begin
      bad++;
      $display("FAIL async_clear got led=%h busy=%b want led=0000 busy=0", led_out, busy);
    end
    led_target = 14'h3FFF;
    step();
    step();
    reset = 1'b0;
    check_release();
    push_exp(4, 1'b1, 1'b1);
    push_exp(8, 1'b1, 1'b1);
    measure(2);
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b1;
    led_target = 14'h0000;
    test_reset();
    test_fade_up();
    test_fade_down();
    test_reversal();
    test_enable();
    test_async_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
